// File: rtl/univ_shift_register_if.sv
// univ_shift_register_if: control/data bundle for univ_shift_register; carries par when SHIFT_REG_PARITY_EN is defined
interface univ_shift_register_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] D;
  logic             sin;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;
`ifdef SHIFT_REG_PARITY_EN
  logic             par;
  modport master (output en, mode, D, sin, start, amt, input q, sout, busy, done, par);
  modport slave (input en, mode, D, sin, start, amt, output q, sout, busy, done, par);
`else
  modport master (output en, mode, D, sin, start, amt, input q, sout, busy, done);
  modport slave (input en, mode, D, sin, start, amt, output q, sout, busy, done);
`endif
endinterface

// File: rtl/univ_shift_register.sv
// univ_shift_register: universal shift register with multi-step engine; SHIFT_REG_PARITY_EN adds par = ^q
module univ_shift_register #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               AMT_W     = 3
) (
  input logic              clk,
  input logic              rest,
  univ_shift_register_if.slave bus
);
  if ((2 ** AMT_W) - 1 < WIDTH) begin : g_amt_chk
    $error("AMT_W too narrow to express WIDTH steps");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [2:0]       op, op_r, op_nx;
  logic [AMT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] q, q_sh;
  logic             sout, sout_sh, multi, apply;
  assign multi    = bus.mode inside {[3'b010:3'b110]};
  assign bus.q    = q;
  assign bus.sout = sout;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
`ifdef SHIFT_REG_PARITY_EN
  assign bus.par  = ^q;
`endif
  // one step of the selected operation; sout only moves on shifts/rotates
  always_comb begin
    q_sh    = q;
    sout_sh = sout;
    case (op)
      3'b001:  q_sh = bus.D;
      3'b010:  {sout_sh, q_sh} = {q, bus.sin};
      3'b011:  {q_sh, sout_sh} = {bus.sin, q};
      3'b100:  {sout_sh, q_sh} = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
      3'b101:  {q_sh, sout_sh} = {q[0], q[WIDTH-1:1], q[0]};
      3'b110:  {q_sh, sout_sh} = {q[WIDTH-1], q};
      3'b111:  q_sh = '0;
      default: ;
    endcase
  end
  // sequencing: single steps in IDLE, latched op repeated in RUN, one-cycle DONE
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_r;
    op       = bus.mode;
    apply    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && multi) begin
          op_nx    = bus.mode;
          cnt_nx   = bus.amt;
          state_nx = (bus.amt != '0) ? RUN : DONE;
        end else apply = 1'b1;
      end
      RUN: begin
        op       = op_r;
        apply    = 1'b1;
        cnt_nx   = cnt - 1'b1;
        state_nx = (cnt == AMT_W'(1)) ? DONE : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state and datapath registers; en low freezes everything
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      q     <= RESET_VAL;
      sout  <= 1'b0;
    end else if (bus.en) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op_r  <= op_nx;
      if (apply) begin
        q    <= q_sh;
        sout <= sout_sh;
      end
    end
  end
endmodule

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register: directed checks of univ_shift_register (WIDTH=4, RESET_VAL=0)
module tb_univ_shift_register;
  logic clk = 1'b0;
  logic rest;
  int   vectors = 0;
  int   miscompares = 0;
  univ_shift_register_if #(.WIDTH(4), .AMT_W(3)) bus ();
  univ_shift_register #(.WIDTH(4), .RESET_VAL(4'b0000), .AMT_W(3)) dut (
    .clk(clk),
    .rest(rest),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {3'b000, obs}, {3'b000, exp});
  endtask
  task automatic chkq(input string tag, input logic [3:0] exp);
    chk(tag, bus.q, exp);
`ifdef SHIFT_REG_PARITY_EN
    chk1({tag, "_par"}, bus.par, ^exp);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rest = 1'b0; bus.en = 1'b0; bus.mode = 3'b000; bus.D = 4'b0000;
    bus.sin = 1'b0; bus.start = 1'b0; bus.amt = 3'd0;
    #2;
    chkq("rst_q", 4'b0000);
    chk1("rst_sout", bus.sout, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    #1 rest = 1'b1;
    bus.en = 1'b1; bus.mode = 3'b001; bus.D = 4'b1010;
    tick; chkq("load_1010", 4'b1010);
    #2 rest = 1'b0;
    #1 chkq("async_rst_q", 4'b0000);
    chk1("async_rst_busy", bus.busy, 1'b0);
    chk1("async_rst_done", bus.done, 1'b0);
    #1 rest = 1'b1; bus.mode = 3'b000;
    tick; chkq("hold_after_rst", 4'b0000);
    bus.mode = 3'b001; bus.D = 4'b1011;
    tick; chkq("load_1011", 4'b1011);
    bus.en = 1'b0; bus.D = 4'b0000;
    tick; chkq("en_low_stall", 4'b1011);
    bus.en = 1'b1; bus.D = 4'b1001;
    tick; chkq("load_1001", 4'b1001);
    bus.mode = 3'b100;
    tick; chkq("rol_q", 4'b0011); chk1("rol_sout", bus.sout, 1'b1);
    bus.mode = 3'b011; bus.sin = 1'b1;
    tick; chkq("shr_q", 4'b1001); chk1("shr_sout", bus.sout, 1'b1);
    bus.mode = 3'b010; bus.sin = 1'b0;
    tick; chkq("shl_q", 4'b0010); chk1("shl_sout", bus.sout, 1'b1);
    bus.mode = 3'b101;
    tick; chkq("ror_q", 4'b0001); chk1("ror_sout", bus.sout, 1'b0);
    bus.mode = 3'b111;
    tick; chkq("clear_q", 4'b0000);
    bus.mode = 3'b001; bus.D = 4'b0001;
    tick; chkq("load_0001", 4'b0001);
    bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 3'd3;
    tick; chkq("ms_start_q", 4'b0001); chk1("ms_start_busy", bus.busy, 1'b1);
    chk1("ms_start_done", bus.done, 1'b0);
    bus.start = 1'b0; bus.mode = 3'b001; bus.D = 4'b1111;
    tick; chkq("ms_step1", 4'b0010); chk1("ms_busy1", bus.busy, 1'b1);
    tick; chkq("ms_step2", 4'b0100); chk1("ms_busy2", bus.busy, 1'b1);
    bus.mode = 3'b000;
    tick; chkq("ms_step3", 4'b1000); chk1("ms_done", bus.done, 1'b1);
    chk1("ms_busy_off", bus.busy, 1'b0); chk1("ms_sout", bus.sout, 1'b0);
    bus.en = 1'b0;
    tick; chk1("done_hold_en0", bus.done, 1'b1); chkq("done_hold_q", 4'b1000);
    bus.en = 1'b1; bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 3'd1;
    tick; chk1("done_pulse_end", bus.done, 1'b0);
    chk1("start_in_done_ign", bus.busy, 1'b0); chkq("after_done_q", 4'b1000);
    bus.mode = 3'b110; bus.amt = 3'd2;
    tick; chk1("asr_busy", bus.busy, 1'b1); chkq("asr_start_q", 4'b1000);
    bus.start = 1'b0; bus.mode = 3'b000;
    tick; chkq("asr_step1", 4'b1100);
    tick; chkq("asr_step2", 4'b1110); chk1("asr_done", bus.done, 1'b1);
    chk1("asr_sout", bus.sout, 1'b0);
    tick; chk1("asr_done_off", bus.done, 1'b0);
    bus.start = 1'b1; bus.mode = 3'b101; bus.amt = 3'd0;
    tick; chk1("amt0_done", bus.done, 1'b1); chk1("amt0_busy", bus.busy, 1'b0);
    chkq("amt0_q", 4'b1110);
    bus.start = 1'b0; bus.mode = 3'b000;
    tick; chk1("amt0_done_off", bus.done, 1'b0); chkq("amt0_q2", 4'b1110);
    bus.start = 1'b1; bus.mode = 3'b010; bus.sin = 1'b1; bus.amt = 3'd6;
    tick; bus.start = 1'b0; bus.mode = 3'b000;
    repeat (6) tick;
    chk1("shl6_done", bus.done, 1'b1); chkq("shl6_q", 4'b1111); chk1("shl6_sout", bus.sout, 1'b1);
    bus.sin = 1'b0; bus.mode = 3'b001; bus.D = 4'b0011;
    tick; chk1("shl6_done_off", bus.done, 1'b0);
    tick; chkq("load_0011", 4'b0011);
    bus.start = 1'b1; bus.mode = 3'b101; bus.amt = 3'd5;
    tick; bus.start = 1'b0; bus.mode = 3'b000;
    repeat (5) tick;
    chk1("ror5_done", bus.done, 1'b1); chkq("ror5_q", 4'b1001);
    tick;
    bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 3'd7;
    tick; bus.start = 1'b0; bus.mode = 3'b000;
    tick; chk1("abort_busy", bus.busy, 1'b1); chkq("abort_pre_q", 4'b0011);
    #2 rest = 1'b0;
    #1 chkq("abort_q", 4'b0000); chk1("abort_busy_off", bus.busy, 1'b0);
    chk1("abort_done", bus.done, 1'b0);
    #1 rest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick; chk1("abort_no_done", bus.done, 1'b0);
    end
    chkq("abort_idle_q", 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
